fetch_stage: RTL

Instruction fetch stage of the 5-stage RV32 pipeline. It owns the PC and issues in-order requests to instruction memory with a valid/ready handshake. It buffers returned instructions in a small FIFO and presents them to decode with their PC. It consumes the hazard unit's `data_flush` as a decode stall and `ctrl_flush` as a redirect, discarding wrong-path instructions, including responses still in flight.

---
 rtl/fetch_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests and buffers responses for decode.
// Decode sees an instruction the cycle after its response; data_flush holds decode, ctrl_flush redirects and squashes.
module fetch_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            data_flush,
   input  logic            ctrl_flush,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid_id,
   output logic [31:0]     inst_id,
   output logic [XLEN-1:0] pc_id
);
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [XLEN-1:0]  r_fetch_pc;
   logic [XLEN-1:0]  r_trk_pc [DEPTH];
   logic [DEPTH-1:0] r_trk_kill;
   logic [AW-1:0]    r_trk_rd;
   logic [AW-1:0]    r_trk_wr;
   logic [CW-1:0]    r_outstanding;
   logic [XLEN-1:0]  r_fifo_pc [DEPTH];
   logic [31:0]      r_fifo_inst [DEPTH];
   logic [AW-1:0]    r_fifo_rd;
   logic [AW-1:0]    r_fifo_wr;
   logic [CW-1:0]    r_fifo_cnt;
   logic [XLEN-1:0]  r_last_pc;
   logic [31:0]      r_last_inst;

   logic             w_empty;
   logic             w_pop;
   logic             w_issue;
   logic             w_resp;
   logic             w_push;
   logic [CW:0]      w_used;

   assign w_empty        = (r_fifo_cnt == '0);
   assign w_pop          = !w_empty && !data_flush && !ctrl_flush;
   // Killed requests still hold credit until their response returns.
   assign w_used         = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt} - {{CW{1'b0}}, w_pop};
   assign imem_req_valid = rst_n && !ctrl_flush && (w_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = r_fetch_pc;
   assign w_issue        = imem_req_valid && imem_req_ready;
   assign w_resp         = imem_resp_valid && (r_outstanding != '0);
   assign w_push         = w_resp && !r_trk_kill[r_trk_rd] && !ctrl_flush;

   assign inst_valid_id  = !w_empty;
   assign inst_id        = w_empty ? r_last_inst : r_fifo_inst[r_fifo_rd];
   assign pc_id          = w_empty ? r_last_pc   : r_fifo_pc[r_fifo_rd];

   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_trk_pc[r_trk_wr] <= r_fetch_pc;
      end
      if (w_push) begin
         r_fifo_pc[r_fifo_wr]   <= r_trk_pc[r_trk_rd];
         r_fifo_inst[r_fifo_wr] <= imem_resp_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_trk_kill    <= '0;
         r_trk_rd      <= '0;
         r_trk_wr      <= '0;
         r_outstanding <= '0;
         r_fifo_rd     <= '0;
         r_fifo_wr     <= '0;
         r_fifo_cnt    <= '0;
         r_last_pc     <= '0;
         r_last_inst   <= NOP;
      end else begin
         if (!w_empty) begin
            r_last_pc   <= pc_id;
            r_last_inst <= inst_id;
         end
         if (w_resp) begin
            r_trk_rd <= r_trk_rd + 1'b1;
         end
         r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_resp);
         if (ctrl_flush) begin
            r_fetch_pc <= redirect_pc;
            r_trk_kill <= '1;
            r_fifo_rd  <= '0;
            r_fifo_wr  <= '0;
            r_fifo_cnt <= '0;
         end else begin
            if (w_issue) begin
               r_trk_kill[r_trk_wr] <= 1'b0;
               r_trk_wr             <= r_trk_wr + 1'b1;
               r_fetch_pc           <= r_fetch_pc + XLEN'(4);
            end
            if (w_push) begin
               r_fifo_wr <= r_fifo_wr + 1'b1;
            end
            if (w_pop) begin
               r_fifo_rd <= r_fifo_rd + 1'b1;
            end
            r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   a_credit : assert property (@(posedge clk) disable iff (!rst_n) w_used <= (CW+1)'(DEPTH));

endmodule
